// File: rtl/scan_display_pkg.sv
// Shared constants and types for the scan_display block.
// Holds the digit count, blanking patterns, the hex-to-segment table
// (active-low, bit order {g,f,e,d,c,b,a}) and the scan FSM state type.
package scan_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    // Element n of the packed array is the pattern for nibble value n.
    localparam logic [15:0][6:0] HEX_SEG = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

    typedef enum logic {
        StBlank,
        StShow
    } state_t;

endpackage

// File: rtl/scan_display_if.sv
// Bundle between the display scanner and its surroundings.
//   num        digit index driven to the nibble selector
//   data       selected nibble returned by the selector
//   dp_en      per-digit decimal point enables
//   an         anode enables, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   frame_tick one-cycle pulse at the end of digit 0's slot
// slave: the scanner side; master: the selector / display side.
interface scan_display_if;
    import scan_display_pkg::*;

    logic [1:0]            num;
    logic [3:0]            data;
    logic [NUM_DIGITS-1:0] dp_en;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_tick;

    modport slave (
        output num, an, seg, dp, frame_tick,
        input  data, dp_en
    );

    modport master (
        input  num, an, seg, dp, frame_tick,
        output data, dp_en
    );

endinterface

// File: rtl/scan_display_hex7seg.sv
// hex7seg: purely combinational hex nibble to seven-segment decoder.
//   nibble  in  4  value to display
//   seg     out 7  active-low segments {g,f,e,d,c,b,a}
module hex7seg
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/scan_display.sv
// scan_display: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Each digit slot lasts DIGIT_CYCLES clocks; the first
// BLANK_CYCLES of each slot keep all anodes off so the nibble selector can
// settle and no ghosting occurs. Scan order is digit 3,2,1,0.
// Parameters: DIGIT_CYCLES (>= 4), BLANK_CYCLES (1 <= BLANK_CYCLES < DIGIT_CYCLES).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    scan_display_if.slave (num, data, dp_en, an, seg, dp, frame_tick)
// Optional build macro SCAN_DISPLAY_LZ_SUPPRESS_EN enables leading-zero
// suppression on digits 3..1.
module scan_display
    import scan_display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_display_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       num_q, num_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;
    logic [6:0]       dec_seg;
    logic             slot_end;
    logic             show_edge;

`ifdef SCAN_DISPLAY_LZ_SUPPRESS_EN
    logic lz_q, lz_d;
`endif

    hex7seg u_hex7seg (
        .nibble (bus.data),
        .seg    (dec_seg)
    );

    assign slot_end  = (cnt_q == CNT_LAST);
    assign show_edge = (state_q == StBlank) && (cnt_q == CNT_SHOW);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBlank;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            state_d = StBlank;
        end else if (show_edge) begin
            state_d = StShow;
        end
    end

    // Output / datapath next-state logic; everything leaves through registers.
    always_comb begin
        cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
        num_d  = num_q;
        an_d   = an_q;
        seg_d  = seg_q;
        dp_d   = dp_q;
        tick_d = 1'b0;
`ifdef SCAN_DISPLAY_LZ_SUPPRESS_EN
        lz_d   = lz_q;
`endif
        if (slot_end) begin
            num_d  = num_q - 2'd1;
            an_d   = AN_OFF;
            seg_d  = SEG_BLANK;
            dp_d   = 1'b1;
            tick_d = (num_q == 2'd0);
`ifdef SCAN_DISPLAY_LZ_SUPPRESS_EN
            // Next slot is digit 3: arm suppression for a new frame.
            if (num_q == 2'd0) begin
                lz_d = 1'b1;
            end
`endif
        end else if (show_edge) begin
`ifdef SCAN_DISPLAY_LZ_SUPPRESS_EN
            // A leading zero stays dark; digit 0 always lights.
            if (lz_q && (num_q != 2'd0) && (bus.data == 4'h0)) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << num_q);
                seg_d = dec_seg;
                dp_d  = ~bus.dp_en[num_q];
                lz_d  = 1'b0;
            end
`else
            an_d  = ~(4'b0001 << num_q);
            seg_d = dec_seg;
            dp_d  = ~bus.dp_en[num_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            num_q  <= 2'b11;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            num_q  <= num_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= tick_d;
        end
    end

`ifdef SCAN_DISPLAY_LZ_SUPPRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q <= 1'b1;
        end else begin
            lz_q <= lz_d;
        end
    end
`endif

    assign bus.num        = num_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule
